// File: rtl/imem_cache.sv
// imem_cache: direct-mapped, read-only instruction cache with a word-serial whole-line refill.
// Latency: a hit answers combinationally in the request cycle; a miss costs at least WORDS+1 cycles until the hit.
// Backpressure: valid stays low for the whole refill; refill beats advance only on mem_rvalid.
// Ports: clk, rst (synchronous, active-high); req/addr/flush lookup inputs; valid/data hit outputs;
//        mem_req/mem_addr refill word request; mem_rdata/mem_rvalid refill beat return.
module imem_cache #(
    parameter int LINES = 16,
    parameter int WORDS = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] addr,
    input  logic        req,
    input  logic        flush,
    output logic [31:0] data,
    output logic        valid,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic [31:0] mem_rdata,
    input  logic        mem_rvalid
);
    localparam int OFF_W  = $clog2(WORDS);
    localparam int IDX_W  = $clog2(LINES);
    localparam int TAG_W  = 30 - OFF_W - IDX_W;
    localparam int BASE_W = 30 - OFF_W;

    typedef enum logic {ST_IDLE, ST_REFILL} state_t;
    state_t state_q, state_d;

    // Line storage; only the valid bits carry a reset.
    logic [LINES-1:0] line_vld_q;
    logic [TAG_W-1:0] tag_q  [LINES];
    logic [31:0]      word_q [LINES][WORDS];

    // Refill bookkeeping: latched line base (word address without offset) and current beat.
    logic [BASE_W-1:0] base_q;
    logic [OFF_W-1:0]  beat_q;
    logic              flush_pend_q;

    logic [OFF_W-1:0] a_word;
    logic [IDX_W-1:0] a_idx;
    logic [TAG_W-1:0] a_tag;
    logic [IDX_W-1:0] r_idx;
    logic [TAG_W-1:0] r_tag;
    logic             hit;
    logic             start_refill;
    logic             beat_done;
    logic             last_beat;
    logic             unused_addr_bits;

    assign a_word = addr[2 +: OFF_W];
    assign a_idx  = addr[2 + OFF_W +: IDX_W];
    assign a_tag  = addr[31 -: TAG_W];
    assign r_idx  = base_q[IDX_W-1:0];
    assign r_tag  = base_q[BASE_W-1 -: TAG_W];
    // Byte offset within the word is irrelevant to a word fetch.
    assign unused_addr_bits = ^addr[1:0];

    always_comb begin
        state_d      = state_q;
        start_refill = 1'b0;
        beat_done    = 1'b0;
        last_beat    = 1'b0;
        valid        = 1'b0;
        data         = '0;
        mem_req      = 1'b0;
        mem_addr     = '0;
        hit          = line_vld_q[a_idx] && (tag_q[a_idx] == a_tag);
        case (state_q)
            ST_IDLE: begin
                // A flush in the same cycle suppresses both the hit and any refill start.
                valid = req && hit && !flush;
                if (valid) begin
                    data = word_q[a_idx][a_word];
                end
                if (req && !hit && !flush) begin
                    start_refill = 1'b1;
                    state_d      = ST_REFILL;
                end
            end
            ST_REFILL: begin
                // Address comes only from registered base/beat, so it is stable until mem_rvalid.
                mem_req   = 1'b1;
                mem_addr  = {base_q, beat_q, 2'b00};
                beat_done = mem_rvalid;
                last_beat = mem_rvalid && (beat_q == OFF_W'(WORDS - 1));
                if (last_beat) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            line_vld_q   <= '0;
            flush_pend_q <= 1'b0;
            beat_q       <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == ST_IDLE) begin
                if (flush) begin
                    line_vld_q <= '0;
                end
                if (start_refill) begin
                    beat_q <= '0;
                end
            end else begin
                if (flush) begin
                    flush_pend_q <= 1'b1;
                end
                if (beat_done) begin
                    beat_q <= beat_q + 1'b1;
                end
                if (last_beat) begin
                    flush_pend_q <= 1'b0;
                    // A flush seen at any point of the refill also kills the line just filled.
                    if (flush_pend_q || flush) begin
                        line_vld_q <= '0;
                    end else begin
                        line_vld_q[r_idx] <= 1'b1;
                    end
                end
            end
        end
    end

    // Unreset payload; a partially written line is harmless because its valid bit stays clear.
    always_ff @(posedge clk) begin
        if (start_refill) begin
            base_q <= addr[31 -: BASE_W];
        end
        if (beat_done && !rst) begin
            word_q[r_idx][beat_q] <= mem_rdata;
        end
        if (last_beat && !rst) begin
            tag_q[r_idx] <= r_tag;
        end
    end
endmodule

// File: tb/tb_imem_cache.sv
// tb_imem_cache: scoreboard bench for imem_cache (LINES=16, WORDS=4).
// Stimulus pushes one expected output record per cycle; a monitor pops and compares on the falling edge.
// The reference model tracks resident line numbers per index and an abstract refill in progress.
module tb_imem_cache;
    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] addr;
    logic        req;
    logic        flush;
    logic [31:0] data;
    logic        valid;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic [31:0] mem_rdata;
    logic        mem_rvalid;

    always #5 clk = ~clk;

    imem_cache #(.LINES(16), .WORDS(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .addr      (addr),
        .req       (req),
        .flush     (flush),
        .data      (data),
        .valid     (valid),
        .mem_req   (mem_req),
        .mem_addr  (mem_addr),
        .mem_rdata (mem_rdata),
        .mem_rvalid(mem_rvalid)
    );

    typedef struct {
        int          cyc;
        logic        vld;
        logic [31:0] dat;
        logic        mreq;
        logic [31:0] maddr;
    } exp_t;

    exp_t expq[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;

    // Reference model state.
    bit          m_ok   [16];
    int unsigned m_line [16];
    bit          m_busy;
    logic [31:0] m_base;
    int          m_beats;
    bit          m_fl;
    int          stall_n  = 0;
    int          wait_cnt = 0;

    logic [31:0] pre_mem [bit [31:0]];

    // Instruction memory contents are fixed, so any valid cached word equals memory.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        logic [31:0] w;
        w = {a[31:2], 2'b00};
        if (pre_mem.exists(w)) return pre_mem[w];
        return (w * 32'h9E37_79B1) ^ 32'h0BAD_F00D;
    endfunction

    task automatic clear_model();
        foreach (m_ok[i]) m_ok[i] = 1'b0;
    endtask

    // One clock cycle: drive inputs, push the expected outputs, advance the model.
    task automatic step(input bit r, input bit q, input logic [31:0] a, input bit f,
                        input int rv, output bit hit_seen);
        exp_t        e;
        bit          rvb;
        bit          hit;
        int          idx;
        int unsigned ln;
        idx = int'((a >> 4) & 32'hF);
        ln  = a >> 4;
        hit = 1'b0;
        if (m_busy) begin
            if (rv < 0) begin
                rvb      = (wait_cnt >= stall_n);
                wait_cnt = rvb ? 0 : wait_cnt + 1;
            end else begin
                rvb = (rv != 0);
            end
        end else begin
            rvb = (rv < 0) ? 1'($urandom_range(0, 1)) : (rv != 0);
        end
        rst        = r;
        req        = q;
        addr       = a;
        flush      = f;
        mem_rvalid = rvb;
        mem_rdata  = m_busy ? mem_word(m_base + 32'(4 * m_beats)) : $urandom;

        e.cyc = cyc;
        if (m_busy) begin
            e.vld   = 1'b0;
            e.dat   = '0;
            e.mreq  = 1'b1;
            e.maddr = m_base + 32'(4 * m_beats);
        end else begin
            hit     = m_ok[idx] && (m_line[idx] == ln);
            e.vld   = q && hit && !f;
            e.dat   = e.vld ? mem_word(a) : 32'h0;
            e.mreq  = 1'b0;
            e.maddr = '0;
        end
        expq.push_back(e);
        hit_seen = e.vld;

        if (r) begin
            m_busy   = 1'b0;
            m_fl     = 1'b0;
            wait_cnt = 0;
            clear_model();
        end else if (m_busy) begin
            if (f) m_fl = 1'b1;
            if (rvb) begin
                m_beats++;
                if (m_beats == 4) begin
                    m_busy = 1'b0;
                    if (m_fl) begin
                        clear_model();
                    end else begin
                        m_ok[(m_base >> 4) & 32'hF]   = 1'b1;
                        m_line[(m_base >> 4) & 32'hF] = m_base >> 4;
                    end
                    m_fl = 1'b0;
                end
            end
        end else if (f) begin
            clear_model();
        end else if (q && !hit) begin
            m_busy   = 1'b1;
            m_base   = a & ~32'hF;
            m_beats  = 0;
            wait_cnt = 0;
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Hold a request until it hits; optionally flush or reset at a given refill beat (one-shot).
    task automatic fetch(input logic [31:0] a, input int fl_beat, input int rst_beat);
        bit h;
        bit f;
        bit r;
        bit fl_done;
        bit rs_done;
        h       = 1'b0;
        fl_done = 1'b0;
        rs_done = 1'b0;
        for (int n = 0; n < 80 && !h; n++) begin
            f = m_busy && (m_beats == fl_beat) && !fl_done;
            r = m_busy && (m_beats == rst_beat) && !rs_done;
            if (f) fl_done = 1'b1;
            if (r) rs_done = 1'b1;
            step(r, 1'b1, a, f, -1, h);
        end
    endtask

    // Monitor: one record per cycle, compared away from the active edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (expq.size() > 0) begin
                e = expq.pop_front();
                checks++;
                if (valid !== e.vld || data !== e.dat) begin
                    errors++;
                    $display("FAIL lookup cyc=%0d: valid=%b data=%h, required valid=%b data=%h",
                             e.cyc, valid, data, e.vld, e.dat);
                end
                checks++;
                if (mem_req !== e.mreq || mem_addr !== e.maddr) begin
                    errors++;
                    $display("FAIL refill cyc=%0d: mem_req=%b mem_addr=%h, required mem_req=%b mem_addr=%h",
                             e.cyc, mem_req, mem_addr, e.mreq, e.maddr);
                end
            end
        end
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1);
    end

    initial begin
        bit          h;
        logic [31:0] a;
        logic [31:0] prev;
        rst        = 1'b1;
        req        = 1'b0;
        addr       = '0;
        flush      = 1'b0;
        mem_rvalid = 1'b0;
        mem_rdata  = '0;
        for (int i = 0; i < 4; i++) pre_mem[32'h100 + 32'(4 * i)] = 32'hA0 + 32'(i);
        m_busy  = 1'b0;
        m_fl    = 1'b0;
        m_beats = 0;
        m_base  = '0;
        clear_model();
        repeat (2) @(posedge clk);
        #1;
        step(1'b1, 1'b0, 32'h0, 1'b0, 0, h);

        // Cold miss with one beat per cycle, then hits across the line.
        fetch(32'h0000_0104, -1, -1);
        step(1'b0, 1'b1, 32'h100, 1'b0, -1, h);
        step(1'b0, 1'b1, 32'h108, 1'b0, -1, h);
        step(1'b0, 1'b1, 32'h10C, 1'b0, -1, h);

        // Conflict eviction on index 0.
        fetch(32'h0000_0200, -1, -1);
        step(1'b0, 1'b1, 32'h204, 1'b0, -1, h);
        fetch(32'h0000_0100, -1, -1);

        // Stalled memory: three idle cycles before each beat.
        stall_n = 3;
        fetch(32'h0000_0348, -1, -1);
        stall_n = 0;

        // Flush in IDLE against a hitting request, then a miss next cycle.
        step(1'b0, 1'b1, 32'h108, 1'b1, -1, h);
        fetch(32'h0000_0108, -1, -1);

        // Flush during the second beat: refill completes but the line does not survive.
        fetch(32'h0000_0184, 1, -1);

        // Reset after two beats: refill restarts from the line base.
        fetch(32'h0000_01C8, -1, 2);

        // Randomized traffic.
        prev = 32'h100;
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 1) == 1) begin
                a = prev;
            end else begin
                a = (32'($urandom_range(0, 1)) << 20) | (32'($urandom_range(0, 127)) << 2)
                    | 32'($urandom_range(0, 3));
            end
            prev = a;
            step($urandom_range(0, 199) == 0, $urandom_range(0, 9) != 0, a,
                 $urandom_range(0, 39) == 0, ($urandom_range(0, 2) != 0) ? 1 : 0, h);
        end

        step(1'b0, 1'b0, 32'h0, 1'b0, 0, h);
        @(negedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
